// File: rtl/serial_frame_pkg.sv
// Shared definitions for the serial frame receiver.
// Contents:
//   rx_state_e  - receiver FSM states (IDLE, DATA, PARITY, STOP)
//   *_LVL       - serial line levels for idle, start and stop bits
//   cnt_width() - bit-counter width able to count 0..data_w
package serial_frame_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_DATA   = 2'd1,
    ST_PARITY = 2'd2,
    ST_STOP   = 2'd3
  } rx_state_e;

  localparam logic IDLE_LVL  = 1'b1;
  localparam logic START_LVL = 1'b0;
  localparam logic STOP_LVL  = 1'b1;

  function automatic int cnt_width(input int data_w);
    return $clog2(data_w + 1);
  endfunction

endpackage

// File: rtl/serial_frame_rx_if.sv
// Parallel valid/ready word interface between the frame receiver and its consumer.
// Signals:
//   out_data  - recovered word (producer -> consumer)
//   out_valid - out_data holds an unconsumed word (producer -> consumer)
//   out_ready - consumer takes the word on a valid && ready edge (consumer -> producer)
// Modports: master = receiver side, slave = consumer side.
interface serial_frame_rx_if #(
  parameter int DATA_W = 8
) ();

  logic [DATA_W-1:0] out_data;
  logic              out_valid;
  logic              out_ready;

  modport master (output out_data, output out_valid, input out_ready);
  modport slave  (input out_data, input out_valid, output out_ready);

endinterface

// File: rtl/rx_hold_reg.sv
// Single-entry valid/ready holding register for received words.
// Ports:
//   clk, reset - clock, asynchronous active-low reset
//   load       - store load_data this edge (only asserted when free = 1)
//   load_data  - word to store
//   ready      - consumer ready
//   data/valid - held word and its valid flag
//   free       - the register can take a word this edge (empty, or being consumed)
module rx_hold_reg #(
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              load,
  input  logic [DATA_W-1:0] load_data,
  input  logic              ready,
  output logic [DATA_W-1:0] data,
  output logic              valid,
  output logic              free
);

  assign free = !valid || ready;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      data  <= '0;
      valid <= 1'b0;
    end else if (load) begin
      // A load on a consuming edge simply replaces the word and keeps valid high.
      data  <= load_data;
      valid <= 1'b1;
    end else if (valid && ready) begin
      valid <= 1'b0;
    end
  end

endmodule

// File: rtl/serial_frame_rx.sv
// Serial frame receiver: start bit, DATA_W data bits (LSB first), optional
// even parity bit, stop bit. One serial bit is sampled per clock edge.
// Ports:
//   clk         - clock
//   reset       - asynchronous active-low reset
//   datain      - serial stream, idle high
//   out_if      - valid/ready word output (master modport)
//   parity_err  - 1-cycle pulse, parity mismatch, word discarded
//   framing_err - 1-cycle pulse, stop bit low, word discarded
//   overrun     - 1-cycle pulse, good word dropped because the holder was full
module serial_frame_rx
  import serial_frame_pkg::*;
#(
  parameter int DATA_W    = 8,
  parameter int PARITY_EN = 1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 datain,
  serial_frame_rx_if.master    out_if,
  output logic                 parity_err,
  output logic                 framing_err,
  output logic                 overrun
);

  localparam int              CNT_W    = cnt_width(DATA_W);
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_W - 1);

  localparam logic [1:0] IDLE   = ST_IDLE;
  localparam logic [1:0] DATA   = ST_DATA;
  localparam logic [1:0] PARITY = ST_PARITY;
  localparam logic [1:0] STOP   = ST_STOP;

  logic [1:0]        state_reg;
  logic [DATA_W-1:0] shift_reg;
  logic [CNT_W-1:0]  cnt_reg;
  logic              par_reg;    // running XOR of data bits, then of the parity bit

  logic              stop_edge;
  logic              mismatch;
  logic              good_word;
  logic              hold_free;
  logic              load;
  logic [DATA_W-1:0] hold_data;
  logic              hold_valid;

  assign stop_edge = (state_reg == STOP);
  // With parity disabled the accumulator still holds the data XOR, so mask it.
  assign mismatch  = (PARITY_EN != 0) && par_reg;
  assign good_word = stop_edge && (datain == STOP_LVL) && !mismatch;
  assign load      = good_word && hold_free;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg   <= IDLE;
      shift_reg   <= '0;
      cnt_reg     <= '0;
      par_reg     <= 1'b0;
      parity_err  <= 1'b0;
      framing_err <= 1'b0;
      overrun     <= 1'b0;
    end else begin
      // Framing error wins over parity error; the three pulses are exclusive.
      framing_err <= stop_edge && (datain != STOP_LVL);
      parity_err  <= stop_edge && (datain == STOP_LVL) && mismatch;
      overrun     <= good_word && !hold_free;

      case (state_reg)
        IDLE: begin
          if (datain == START_LVL) begin
            state_reg <= DATA;
            cnt_reg   <= '0;
            par_reg   <= 1'b0;
          end
        end
        DATA: begin
          // Right shift: the first-received bit ends up at bit 0.
          shift_reg <= {datain, shift_reg[DATA_W-1:1]};
          par_reg   <= par_reg ^ datain;
          cnt_reg   <= cnt_reg + 1'b1;
          if (cnt_reg == LAST_BIT) begin
            state_reg <= (PARITY_EN != 0) ? PARITY : STOP;
          end
        end
        PARITY: begin
          par_reg   <= par_reg ^ datain;
          state_reg <= STOP;
        end
        STOP: begin
          // No idle gap needed: the next edge can already see a start bit.
          state_reg <= IDLE;
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  rx_hold_reg #(.DATA_W(DATA_W)) u_hold (
    .clk       (clk),
    .reset     (reset),
    .load      (load),
    .load_data (shift_reg),
    .ready     (out_if.out_ready),
    .data      (hold_data),
    .valid     (hold_valid),
    .free      (hold_free)
  );

  assign out_if.out_data  = hold_data;
  assign out_if.out_valid = hold_valid;

endmodule

// File: tb/tb_serial_frame_rx.sv
// Testbench for serial_frame_rx: one DUT with parity (dut1) and one without (dut0).
// A frame-level reference model (expected word/valid and error pulses) is
// updated every clock and compared with the selected DUT's outputs.
module tb_serial_frame_rx;

  localparam int EV_NONE = 0;
  localparam int EV_GOOD = 1;
  localparam int EV_PERR = 2;
  localparam int EV_FERR = 3;

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic datain1 = 1'b1;
  logic datain0 = 1'b1;
  logic rdy = 1'b0;
  logic perr1, ferr1, ovr1, perr0, ferr0, ovr0;

  serial_frame_rx_if #(.DATA_W(8)) if1 ();
  serial_frame_rx_if #(.DATA_W(8)) if0 ();
  assign if1.out_ready = rdy;
  assign if0.out_ready = rdy;

  serial_frame_rx #(.DATA_W(8), .PARITY_EN(1)) dut1 (
    .clk(clk), .reset(reset), .datain(datain1), .out_if(if1),
    .parity_err(perr1), .framing_err(ferr1), .overrun(ovr1));

  serial_frame_rx #(.DATA_W(8), .PARITY_EN(0)) dut0 (
    .clk(clk), .reset(reset), .datain(datain0), .out_if(if0),
    .parity_err(perr0), .framing_err(ferr0), .overrun(ovr0));

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Bench state
  bit       sel = 1'b1;       // 1: drive/check dut1, 0: dut0
  int       ready_mode = 1;   // 0: never ready, 1: always ready, 2: random
  bit       m_valid = 1'b0;
  logic [7:0] m_data = 8'h00;
  int       cyc = 0;
  int       frame_edge = 0;
  int       valid_rise_edge = -1;
  logic [7:0] rise_data = 8'h00;
  bit       prev_valid = 1'b0;
  int       perr_cnt = 0, ferr_cnt = 0, ovr_cnt = 0;

  function automatic logic next_ready();
    if (ready_mode == 0) return 1'b0;
    if (ready_mode == 1) return 1'b1;
    return logic'($urandom_range(0, 1));
  endfunction

  // One clock: drive a serial bit and ready, advance, update the model, compare.
  task automatic run_cycle(input logic b, input logic rdy_in, input int ev, input logic [7:0] w);
    logic e_p, e_f, e_o, o_v, o_p, o_f, o_o;
    logic [7:0] o_d;
    if (sel) begin datain1 = b; datain0 = 1'b1; end
    else     begin datain0 = b; datain1 = 1'b1; end
    rdy = rdy_in;
    @(posedge clk);
    #1;
    cyc++;
    frame_edge++;
    e_p = 1'b0; e_f = 1'b0; e_o = 1'b0;
    case (ev)
      EV_GOOD: begin
        if (!m_valid || rdy_in) begin m_valid = 1'b1; m_data = w; end
        else e_o = 1'b1;
      end
      EV_PERR: begin e_p = 1'b1; if (m_valid && rdy_in) m_valid = 1'b0; end
      EV_FERR: begin e_f = 1'b1; if (m_valid && rdy_in) m_valid = 1'b0; end
      default: if (m_valid && rdy_in) m_valid = 1'b0;
    endcase
    if (sel) begin o_v = if1.out_valid; o_d = if1.out_data; o_p = perr1; o_f = ferr1; o_o = ovr1; end
    else     begin o_v = if0.out_valid; o_d = if0.out_data; o_p = perr0; o_f = ferr0; o_o = ovr0; end
    if (!prev_valid && o_v && valid_rise_edge < 0) begin
      valid_rise_edge = frame_edge;
      rise_data = o_d;
    end
    prev_valid = o_v;
    perr_cnt += int'(o_p); ferr_cnt += int'(o_f); ovr_cnt += int'(o_o);
    checks++;
    if (o_v !== m_valid) begin errors++; $display("FAIL out_valid cyc %0d got %0b exp %0b", cyc, o_v, m_valid); end
    checks++;
    if (o_d !== m_data) begin errors++; $display("FAIL out_data cyc %0d got %02h exp %02h", cyc, o_d, m_data); end
    checks++;
    if (o_p !== e_p) begin errors++; $display("FAIL parity_err cyc %0d got %0b exp %0b", cyc, o_p, e_p); end
    checks++;
    if (o_f !== e_f) begin errors++; $display("FAIL framing_err cyc %0d got %0b exp %0b", cyc, o_f, e_f); end
    checks++;
    if (o_o !== e_o) begin errors++; $display("FAIL overrun cyc %0d got %0b exp %0b", cyc, o_o, e_o); end
  endtask

  // Sends one frame; flip corrupts the parity bit, stop_b is the stop bit level.
  task automatic send_frame(input logic [7:0] d, input bit flip, input logic stop_b,
                            input int gap, input bit rdy_stop);
    int ev;
    frame_edge = 0;
    valid_rise_edge = -1;
    run_cycle(1'b0, next_ready(), EV_NONE, 8'h00);
    for (int i = 0; i < 8; i++) run_cycle(d[i], next_ready(), EV_NONE, 8'h00);
    if (sel) run_cycle((^d) ^ flip, next_ready(), EV_NONE, 8'h00);
    if (!stop_b) ev = EV_FERR;
    else if (sel && flip) ev = EV_PERR;
    else ev = EV_GOOD;
    run_cycle(stop_b, rdy_stop ? 1'b1 : next_ready(), ev, d);
    for (int i = 0; i < gap; i++) run_cycle(1'b1, next_ready(), EV_NONE, 8'h00);
    $display("frame dut%0d data=%02h flip=%0b stop=%0b gap=%0d event=%0d", sel ? 1 : 0, d, flip, stop_b, gap, ev);
  endtask

  task automatic clear_counts();
    perr_cnt = 0; ferr_cnt = 0; ovr_cnt = 0;
  endtask

  task automatic do_reset();
    datain1 = 1'b1; datain0 = 1'b1; rdy = 1'b0;
    @(negedge clk); reset = 1'b0;
    @(negedge clk); reset = 1'b1;
    @(posedge clk); #1;
    m_valid = 1'b0; m_data = 8'h00; prev_valid = 1'b0;
  endtask

  task automatic test_reset();
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if ({if1.out_valid, if1.out_data, perr1, ferr1, ovr1} !== 12'h000) begin
      errors++; $display("FAIL reset_dut1 got %03h exp 000", {if1.out_valid, if1.out_data, perr1, ferr1, ovr1});
    end
    checks++;
    if ({if0.out_valid, if0.out_data, perr0, ferr0, ovr0} !== 12'h000) begin
      errors++; $display("FAIL reset_dut0 got %03h exp 000", {if0.out_valid, if0.out_data, perr0, ferr0, ovr0});
    end
    @(negedge clk); reset = 1'b1;
    @(posedge clk); #1;
    $display("reset released");
  endtask

  task automatic test_basic();
    sel = 1'b1; ready_mode = 1; clear_counts();
    send_frame(8'hA5, 1'b0, 1'b1, 2, 1'b0);
    checks++;
    if (valid_rise_edge !== 11) begin errors++; $display("FAIL basic_latency got %0d exp 11", valid_rise_edge); end
    checks++;
    if (rise_data !== 8'hA5) begin errors++; $display("FAIL basic_data got %02h exp a5", rise_data); end
    checks++;
    if (perr_cnt + ferr_cnt + ovr_cnt !== 0) begin errors++; $display("FAIL basic_pulses got %0d exp 0", perr_cnt + ferr_cnt + ovr_cnt); end
  endtask

  task automatic test_parity_err();
    sel = 1'b1; ready_mode = 1; clear_counts();
    send_frame(8'h3C, 1'b1, 1'b1, 2, 1'b0);
    checks++;
    if (perr_cnt !== 1) begin errors++; $display("FAIL parity_pulse_count got %0d exp 1", perr_cnt); end
    checks++;
    if (valid_rise_edge !== -1) begin errors++; $display("FAIL parity_no_word got edge %0d exp -1", valid_rise_edge); end
  endtask

  task automatic test_framing();
    sel = 1'b1; ready_mode = 1; clear_counts();
    send_frame(8'h3C, 1'b0, 1'b0, 0, 1'b0);
    checks++;
    if (ferr_cnt !== 1 || perr_cnt !== 0) begin
      errors++; $display("FAIL framing_pulses got f%0d p%0d exp f1 p0", ferr_cnt, perr_cnt);
    end
    send_frame(8'h96, 1'b0, 1'b1, 1, 1'b0);
    checks++;
    if (valid_rise_edge !== 11 || rise_data !== 8'h96) begin
      errors++; $display("FAIL framing_next got edge %0d data %02h exp 11 96", valid_rise_edge, rise_data);
    end
  endtask

  task automatic test_overrun();
    sel = 1'b1; ready_mode = 0; clear_counts();
    send_frame(8'h11, 1'b0, 1'b1, 0, 1'b0);
    send_frame(8'h22, 1'b0, 1'b1, 0, 1'b0);
    checks++;
    if (ovr_cnt !== 1) begin errors++; $display("FAIL overrun_count got %0d exp 1", ovr_cnt); end
    checks++;
    if (if1.out_valid !== 1'b1 || if1.out_data !== 8'h11) begin
      errors++; $display("FAIL overrun_hold got v%0b %02h exp v1 11", if1.out_valid, if1.out_data);
    end
    ready_mode = 1;
    run_cycle(1'b1, 1'b1, EV_NONE, 8'h00);
    checks++;
    if (if1.out_valid !== 1'b0) begin errors++; $display("FAIL overrun_drain got %0b exp 0", if1.out_valid); end
  endtask

  task automatic test_back_to_back();
    sel = 1'b1; ready_mode = 0; clear_counts();
    send_frame(8'h11, 1'b0, 1'b1, 0, 1'b0);
    send_frame(8'h22, 1'b0, 1'b1, 0, 1'b1);
    checks++;
    if (if1.out_valid !== 1'b1 || if1.out_data !== 8'h22 || ovr_cnt !== 0) begin
      errors++; $display("FAIL consume_load got v%0b %02h ovr%0d exp v1 22 ovr0", if1.out_valid, if1.out_data, ovr_cnt);
    end
    ready_mode = 1;
    run_cycle(1'b1, 1'b1, EV_NONE, 8'h00);
  endtask

  task automatic test_mid_reset();
    sel = 1'b1; ready_mode = 0;
    send_frame(8'h77, 1'b0, 1'b1, 0, 1'b0);
    run_cycle(1'b0, 1'b0, EV_NONE, 8'h00);
    for (int i = 0; i < 4; i++) run_cycle(logic'(i[0]), 1'b0, EV_NONE, 8'h00);
    #2 reset = 1'b0;
    #1;
    checks++;
    if ({if1.out_valid, if1.out_data, perr1, ferr1, ovr1} !== 12'h000) begin
      errors++; $display("FAIL mid_reset_outputs got %03h exp 000", {if1.out_valid, if1.out_data, perr1, ferr1, ovr1});
    end
    datain1 = 1'b1;
    @(posedge clk);
    @(negedge clk) reset = 1'b1;
    @(posedge clk); #1;
    m_valid = 1'b0; m_data = 8'h00; prev_valid = 1'b0;
    ready_mode = 1; clear_counts();
    send_frame(8'h5A, 1'b0, 1'b1, 1, 1'b0);
    checks++;
    if (valid_rise_edge !== 11 || rise_data !== 8'h5A) begin
      errors++; $display("FAIL mid_reset_frame got edge %0d data %02h exp 11 5a", valid_rise_edge, rise_data);
    end
  endtask

  task automatic test_no_parity();
    sel = 1'b0; ready_mode = 1;
    do_reset();
    clear_counts();
    send_frame(8'h5A, 1'b0, 1'b1, 1, 1'b0);
    checks++;
    if (valid_rise_edge !== 10 || rise_data !== 8'h5A) begin
      errors++; $display("FAIL no_parity_frame got edge %0d data %02h exp 10 5a", valid_rise_edge, rise_data);
    end
    sel = 1'b1;
    do_reset();
  endtask

  task automatic test_random();
    logic [7:0] d;
    bit flip;
    logic stop_b;
    sel = 1'b1; ready_mode = 2;
    for (int n = 0; n < 40; n++) begin
      d = 8'($urandom);
      flip = ($urandom_range(0, 5) == 0);
      stop_b = ($urandom_range(0, 7) != 0);
      send_frame(d, flip, stop_b, $urandom_range(0, 2), 1'b0);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_parity_err();
    test_framing();
    test_overrun();
    test_back_to_back();
    test_mid_reset();
    test_no_parity();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
